// File: rtl/box_stat.sv
// Scans one level of the box-count RAM in raster order and reduces it to occupied-box count,
// saturating mass and second-moment sums, and the peak box value.
module box_stat #(
   parameter int unsigned BOX_IDX  = 3,
   parameter int unsigned DATA_LEN = 8,
   parameter int unsigned ACC_LEN  = 24
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                start,
   input  logic [BOX_IDX-1:0]  side_log,
   input  logic                bank,
   output logic [2*BOX_IDX:0]  rd_addr,
   input  logic [DATA_LEN-1:0] rd_data,
   output logic                busy,
   output logic                done,
   output logic [2*BOX_IDX:0]  n_occ,
   output logic [ACC_LEN-1:0]  mass_sum,
   output logic [ACC_LEN-1:0]  sq_sum,
   output logic [DATA_LEN-1:0] max_val,
   output logic                ovf
);

   // Adders are one bit wider than the larger operand so a carry past ACC_LEN is visible.
   localparam int unsigned MS_W = ((ACC_LEN > DATA_LEN) ? ACC_LEN : DATA_LEN) + 1;
   localparam int unsigned SQ_W = ((ACC_LEN > 2 * DATA_LEN) ? ACC_LEN : 2 * DATA_LEN) + 1;
   localparam logic [BOX_IDX-1:0] S_MAX = BOX_IDX'(BOX_IDX);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

   state_t                state;
   logic [BOX_IDX-1:0]    x_cnt;
   logic [BOX_IDX-1:0]    y_cnt;
   logic [BOX_IDX-1:0]    lim;
   logic                  bank_q;
   logic                  valid;

   logic [BOX_IDX-1:0]    s_clamp;
   logic [BOX_IDX:0]      side_pow;
   logic [BOX_IDX-1:0]    lim_new;
   logic [BOX_IDX-1:0]    x_nxt;
   logic [BOX_IDX-1:0]    y_nxt;
   logic                  last;
   logic [2*DATA_LEN-1:0] sq;
   logic [MS_W-1:0]       mass_wide;
   logic [SQ_W-1:0]       sq_wide;
   logic                  mass_sat;
   logic                  sq_sat;

   always_comb begin
      s_clamp  = (side_log > S_MAX) ? S_MAX : side_log;
      side_pow = (BOX_IDX + 1)'(1) << s_clamp;
      lim_new  = BOX_IDX'(side_pow - (BOX_IDX + 1)'(1));

      last = (x_cnt == lim) && (y_cnt == lim);
      if (y_cnt == lim) begin
         y_nxt = '0;
         x_nxt = x_cnt + BOX_IDX'(1);
      end else begin
         y_nxt = y_cnt + BOX_IDX'(1);
         x_nxt = x_cnt;
      end

      sq        = (2 * DATA_LEN)'(rd_data) * (2 * DATA_LEN)'(rd_data);
      mass_wide = MS_W'(mass_sum) + MS_W'(rd_data);
      sq_wide   = SQ_W'(sq_sum) + SQ_W'(sq);
      mass_sat  = |mass_wide[MS_W-1:ACC_LEN];
      sq_sat    = |sq_wide[SQ_W-1:ACC_LEN];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= StIdle;
         x_cnt    <= '0;
         y_cnt    <= '0;
         lim      <= '0;
         bank_q   <= 1'b0;
         valid    <= 1'b0;
         rd_addr  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         n_occ    <= '0;
         mass_sum <= '0;
         sq_sum   <= '0;
         max_val  <= '0;
         ovf      <= 1'b0;
      end else begin
         // rd_data lags rd_addr by one cycle, so the valid pipe trails the RUN state.
         valid <= (state == StRun);

         if (valid) begin
            n_occ    <= n_occ + (2 * BOX_IDX + 1)'(rd_data != '0);
            mass_sum <= mass_sat ? '1 : mass_wide[ACC_LEN-1:0];
            sq_sum   <= sq_sat ? '1 : sq_wide[ACC_LEN-1:0];
            if (rd_data > max_val) begin
               max_val <= rd_data;
            end
            if (mass_sat || sq_sat) begin
               ovf <= 1'b1;
            end
         end

         unique case (state)
            StIdle: begin
               if (start) begin
                  lim      <= lim_new;
                  bank_q   <= bank;
                  x_cnt    <= '0;
                  y_cnt    <= '0;
                  rd_addr  <= {BOX_IDX'(0), bank, BOX_IDX'(0)};
                  n_occ    <= '0;
                  mass_sum <= '0;
                  sq_sum   <= '0;
                  max_val  <= '0;
                  ovf      <= 1'b0;
                  busy     <= 1'b1;
                  state    <= StRun;
               end
            end
            StRun: begin
               if (last) begin
                  state <= StDrain;
               end else begin
                  x_cnt   <= x_nxt;
                  y_cnt   <= y_nxt;
                  rd_addr <= {x_nxt, bank_q, y_nxt};
               end
            end
            StDrain: begin
               done  <= 1'b1;
               state <= StDone;
            end
            StDone: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/box_stat.md
# box_stat

Downstream consumer of the box-count grid-reduction stage. After each coarsening pass has written a level into the box-count RAM, this block scans that level in raster order and reduces it to the statistics used by the multifractal fit. For each level it produces four values:
- occupied-box count N(ε);
- total mass Σμ;
- second moment Σμ²;
- peak box value.

A start/done handshake lets the top-level sequencer step through levels.

## Interface
- BOX_IDX, 3, log2 of full-resolution grid side; RAM address is {x[BOX_IDX], bank, y[BOX_IDX]}
- DATA_LEN, 8, width of one box count
- ACC_LEN, 24, width of mass_sum and sq_sum accumulators
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- start  in  1  level request, sampled only in IDLE
- side_log  in  BOX_IDX  log2 of current grid side; values > BOX_IDX clamp to BOX_IDX
- bank  in  1  RAM bank holding the level; goes into the middle address bit
- rd_addr  out  2*BOX_IDX+1  box-count RAM read address
- rd_data  in  DATA_LEN  RAM read data, valid one cycle after rd_addr (synchronous read)
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse when results are final
- n_occ  out  2*BOX_IDX+1  number of nonzero boxes
- mass_sum  out  ACC_LEN  Σ rd_data, saturating
- sq_sum  out  ACC_LEN  Σ rd_data², saturating
- max_val  out  DATA_LEN  largest rd_data seen
- ovf  out  1  sticky: mass_sum or sq_sum saturated during this level

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: busy=0, outputs hold the previous results.
- start=1 in IDLE:
  - latch s = min(side_log, BOX_IDX) and bank;
  - clear all accumulators, max_val and ovf;
  - enter RUN.
- RUN issues N = 4^s addresses, one per cycle.
  - Order: y increments fastest, from 0 to 2^s−1; x then increments.
  - rd_addr = {x, bank, y}, with x and y zero-extended to BOX_IDX bits.
  - After the last address, enter DRAIN.
- A 1-bit valid pipe register marks cycles where rd_data belongs to an issued address. On each valid cycle:
  - n_occ += (rd_data != 0);
  - mass_sum += rd_data;
  - sq_sum += rd_data*rd_data (2*DATA_LEN-bit product, zero-extended);
  - max_val = max(max_val, rd_data).
- Saturation:
  - any sum that would exceed 2^ACC_LEN−1 sticks at all-ones and sets ovf;
  - once saturated, the sum stays at all-ones.
- DRAIN: accumulates the final datum. Then enter DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- start while not IDLE is ignored, including in the DONE cycle.
- s=0: a single read of address {0, bank, 0}.
- RST asserted at any time, including mid-scan:
  - immediately forces IDLE;
  - busy=0, done=0, rd_addr=0;
  - n_occ, mass_sum, sq_sum, max_val and ovf all 0;
  - the partial scan is discarded.

## Timing
- Reset values: every output is 0.
- Start accepted at edge T.
  - First rd_addr presented in cycle T+1.
  - Last address presented in cycle T+N.
  - DRAIN in cycle T+N+1.
  - done=1 and final results visible in cycle T+N+2.
  - Next start is accepted at edge T+N+3 at the earliest.
- Latency from start to done: N+2 cycles. Throughput: one box per cycle.
- rd_addr is registered and holds its last value outside RUN.
- Result outputs change only during a scan. After done they are stable until the next accepted start.

## Test plan
- s=2, bank=1, RAM all 1s:
  - addresses {0,1,0}, {0,1,1} … {3,1,3};
  - done at T+18;
  - n_occ=16, mass_sum=16, sq_sum=16, max_val=1, ovf=0.
- s=1, bank=0, data 0,3,0,7:
  - n_occ=2, mass_sum=10, sq_sum=58, max_val=7;
  - done at T+6.
- s=0: one read at address 0 (bank bit as set); done at T+3; stats reflect that single value.
- ACC_LEN=10, s=2, all 255:
  - mass_sum and sq_sum saturate to 1023;
  - ovf=1; n_occ=16; max_val=255.
- start pulsed again during RUN: ignored; address sequence and results unchanged.
- RST asserted mid-RUN at s=3:
  - all outputs 0 and state IDLE immediately;
  - a fresh start afterwards completes a full 64-read scan with correct sums.
